// File: rtl/alu_result_buffer.sv
// alu_result_buffer: registered result stage behind the 32-bit ALU.
// Captures result, carryout, overflow and a computed zero flag into a small
// FIFO with valid/ready handshaking toward writeback. It also keeps a sticky
// overflow flag and a saturating overflow-event counter for status reporting.
module alu_result_buffer #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_result,
   input  logic                     in_carryout,
   input  logic                     in_overflow,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_result,
   output logic                     out_carryout,
   output logic                     out_overflow,
   output logic                     out_zero,
   output logic [$clog2(DEPTH):0]   count,
   input  logic                     ovf_clear,
   output logic                     sticky_ovf,
   output logic [7:0]               ovf_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FullCount = (PTR_W + 1)'(DEPTH);

   typedef struct packed {
      logic [WIDTH-1:0] result;
      logic             carryout;
      logic             overflow;
      logic             zero;
   } entry_t;

   entry_t             mem [DEPTH];
   entry_t             head;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               push;
   logic               pop;

   // Handshake flags come from the registered count only, so there is no
   // combinational path from in_valid or out_ready back to the flags.
   assign in_ready  = (count != FullCount);
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // The head entry is read combinationally and forced to zero when empty.
   assign head         = mem[rd_ptr];
   assign out_result   = out_valid ? head.result   : '0;
   assign out_carryout = out_valid ? head.carryout : 1'b0;
   assign out_overflow = out_valid ? head.overflow : 1'b0;
   assign out_zero     = out_valid ? head.zero     : 1'b0;

   // Storage needs no reset; entries are only visible once pushed.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= '{result:   in_result,
                          carryout: in_carryout,
                          overflow: in_overflow,
                          zero:     (in_result == '0)};
      end
   end

   // Pointers wrap naturally at DEPTH; count tracks net push/pop activity.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   // Overflow status follows accepted pushes; a same-cycle overflow push
   // takes priority over a clear, leaving the flag set and the count at one.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sticky_ovf <= 1'b0;
         ovf_count  <= '0;
      end else if (push && in_overflow) begin
         sticky_ovf <= 1'b1;
         if (ovf_clear)               ovf_count <= 8'd1;
         else if (ovf_count != 8'hFF) ovf_count <= ovf_count + 8'd1;
      end else if (ovf_clear) begin
         sticky_ovf <= 1'b0;
         ovf_count  <= '0;
      end
   end

endmodule

// File: tb/tb_alu_result_buffer.sv
// tb_alu_result_buffer: directed and randomized checks of alu_result_buffer
// against a queue-based reference model held in the bench.
module tb_alu_result_buffer;

   localparam int DEPTH = 4;
   localparam int WIDTH = 32;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  in_result;
   logic              in_carryout;
   logic              in_overflow;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  out_result;
   logic              out_carryout;
   logic              out_overflow;
   logic              out_zero;
   logic [2:0]        count;
   logic              ovf_clear;
   logic              sticky_ovf;
   logic [7:0]        ovf_count;

   typedef struct {
      logic [WIDTH-1:0] result;
      logic             carryout;
      logic             overflow;
   } model_entry_t;

   model_entry_t model_q[$];
   bit           model_sticky;
   int           model_ovf_cnt;
   int           n_vectors = 0;
   int           n_miscompares = 0;

   alu_result_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_result    (in_result),
      .in_carryout  (in_carryout),
      .in_overflow  (in_overflow),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_carryout (out_carryout),
      .out_overflow (out_overflow),
      .out_zero     (out_zero),
      .count        (count),
      .ovf_clear    (ovf_clear),
      .sticky_ovf   (sticky_ovf),
      .ovf_count    (ovf_count)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // Single comparison point: counts every vector and reports any miscompare.
   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      n_vectors++;
      assert (observed === expected) else begin
         n_miscompares++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Compares every DUT output with what the reference model says it must be.
   task automatic check_state(input string tag);
      bit          empty;
      logic [31:0] exp_res;
      logic        exp_co;
      logic        exp_ov;
      logic        exp_z;
      empty   = (model_q.size() == 0);
      exp_res = empty ? 32'h0 : model_q[0].result;
      exp_co  = empty ? 1'b0  : model_q[0].carryout;
      exp_ov  = empty ? 1'b0  : model_q[0].overflow;
      exp_z   = empty ? 1'b0  : (model_q[0].result == 32'h0);
      check_output({tag, ".count"},     32'(count),        32'(model_q.size()));
      check_output({tag, ".in_ready"},  32'(in_ready),     32'(model_q.size() < DEPTH));
      check_output({tag, ".out_valid"}, 32'(out_valid),    32'(!empty));
      check_output({tag, ".result"},    out_result,        exp_res);
      check_output({tag, ".carryout"},  32'(out_carryout), 32'(exp_co));
      check_output({tag, ".overflow"},  32'(out_overflow), 32'(exp_ov));
      check_output({tag, ".zero"},      32'(out_zero),     32'(exp_z));
      check_output({tag, ".sticky"},    32'(sticky_ovf),   32'(model_sticky));
      check_output({tag, ".ovf_count"}, 32'(ovf_count),    32'(model_ovf_cnt));
   endtask

   task automatic model_reset();
      model_q.delete();
      model_sticky  = 1'b0;
      model_ovf_cnt = 0;
   endtask

   // Drives one cycle of inputs, advances the model across the edge, then checks.
   task automatic apply_stimulus(input string tag, input bit valid,
                                 input logic [31:0] data, input bit co, input bit ov,
                                 input bit rdy, input bit clr);
      bit           do_push;
      bit           do_pop;
      model_entry_t e;
      @(negedge clk);
      in_valid    = valid;
      in_result   = data;
      in_carryout = co;
      in_overflow = ov;
      out_ready   = rdy;
      ovf_clear   = clr;
      @(posedge clk);
      do_push = valid && (model_q.size() < DEPTH);
      do_pop  = rdy && (model_q.size() > 0);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
         e.result   = data;
         e.carryout = co;
         e.overflow = ov;
         model_q.push_back(e);
      end
      if (do_push && ov) begin
         model_sticky  = 1'b1;
         model_ovf_cnt = clr ? 1 : ((model_ovf_cnt < 255) ? model_ovf_cnt + 1 : 255);
      end else if (clr) begin
         model_sticky  = 1'b0;
         model_ovf_cnt = 0;
      end
      #1;
      check_state(tag);
   endtask

   initial begin
      reset_n     = 1'b0;
      in_valid    = 1'b0;
      in_result   = '0;
      in_carryout = 1'b0;
      in_overflow = 1'b0;
      out_ready   = 1'b0;
      ovf_clear   = 1'b0;
      model_reset();

      // Reset and empty behaviour.
      repeat (3) @(posedge clk);
      #1;
      check_state("reset");
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) apply_stimulus("empty_pop", 0, 32'h0, 0, 0, 1, 0);

      // Ordering and flags.
      apply_stimulus("ord_push0", 1, 32'h0000_0005, 0, 0, 0, 0);
      apply_stimulus("ord_push1", 1, 32'h0000_0000, 1, 0, 0, 0);
      apply_stimulus("ord_push2", 1, 32'h8000_0000, 0, 1, 0, 0);
      check_output("ord_count3", 32'(count), 32'd3);
      check_output("ord_head0_zero", 32'(out_zero), 32'd0);
      apply_stimulus("ord_pop0", 0, 32'h0, 0, 0, 1, 0);
      check_output("ord_head1_zero", 32'(out_zero), 32'd1);
      apply_stimulus("ord_pop1", 0, 32'h0, 0, 0, 1, 0);
      check_output("ord_head2_ovf", 32'(out_overflow), 32'd1);
      apply_stimulus("ord_pop2", 0, 32'h0, 0, 0, 1, 0);

      // Full boundary: no push while full, even with a simultaneous pop.
      for (int i = 0; i < DEPTH; i++)
         apply_stimulus("full_fill", 1, $urandom, 1'($urandom), 0, 0, 0);
      check_output("full_in_ready", 32'(in_ready), 32'd0);
      apply_stimulus("full_reject", 1, 32'hDEAD_BEEF, 0, 0, 1, 0);
      check_output("full_reject_count", 32'(count), 32'd3);
      apply_stimulus("full_accept", 1, 32'hDEAD_BEEF, 0, 0, 0, 0);
      check_output("full_accept_count", 32'(count), 32'd4);
      for (int i = 0; i < DEPTH; i++) apply_stimulus("full_drain", 0, 32'h0, 0, 0, 1, 0);

      // Wrap-around streaming of 0..9 with continuous pop.
      for (int i = 0; i < 10; i++) begin
         apply_stimulus("wrap_stream", 1, 32'(i), 0, 0, 1, 0);
         check_output("wrap_head", out_result, 32'(i));
         check_output("wrap_count_le1", 32'(count <= 3'd1), 32'd1);
      end
      apply_stimulus("wrap_drain", 0, 32'h0, 0, 0, 1, 0);

      // Overflow status saturation and clear priority.
      for (int i = 0; i < 300; i++) apply_stimulus("ovf_sat", 1, $urandom, 0, 1, 1, 0);
      check_output("ovf_sat_count", 32'(ovf_count), 32'd255);
      apply_stimulus("ovf_clr_set", 1, $urandom, 0, 1, 1, 1);
      check_output("ovf_clr_set_count", 32'(ovf_count), 32'd1);
      check_output("ovf_clr_set_sticky", 32'(sticky_ovf), 32'd1);
      apply_stimulus("ovf_clr_only", 0, 32'h0, 0, 0, 1, 1);
      check_output("ovf_clr_only_count", 32'(ovf_count), 32'd0);
      check_output("ovf_clr_only_sticky", 32'(sticky_ovf), 32'd0);

      // Randomized traffic with occasional zero results and clears.
      for (int i = 0; i < 400; i++) begin
         logic [31:0] d;
         d = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
         apply_stimulus("random", 1'($urandom), d, 1'($urandom), 1'($urandom),
                        ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
      end

      // Reset mid-operation discards queued entries immediately.
      apply_stimulus("mid_drain", 0, 32'h0, 0, 0, 1, 0);
      apply_stimulus("mid_drain", 0, 32'h0, 0, 0, 1, 0);
      apply_stimulus("mid_drain", 0, 32'h0, 0, 0, 1, 0);
      apply_stimulus("mid_drain", 0, 32'h0, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) apply_stimulus("mid_fill", 1, $urandom, 0, 1, 0, 0);
      @(negedge clk);
      in_valid = 1'b0;
      reset_n  = 1'b0;
      #1;
      model_reset();
      check_state("mid_reset");
      #2;
      reset_n = 1'b1;
      apply_stimulus("post_reset_push", 1, 32'h0000_000A, 0, 0, 0, 0);
      check_output("post_reset_head", out_result, 32'h0000_000A);
      apply_stimulus("post_reset_pop", 0, 32'h0, 0, 0, 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule

// File: doc/alu_result_buffer.md
# alu_result_buffer

Registered result stage directly downstream of the 32-bit ALU datapath (add/sub, SLT, logic ops). Captures each ALU result with its carryout and overflow, computes a zero flag, and queues the entries in a small FIFO behind a valid/ready handshake toward writeback. Also keeps a sticky overflow flag and a saturating overflow-event counter for the status register.

## Interface
- DEPTH, 4, number of FIFO entries; power of two, at least 2
- WIDTH, 32, result width

- clk  input  1  single clock; all state updates on the rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  ALU presents a result this cycle
- in_ready  output  1  buffer can accept; high when count < DEPTH
- in_result  input  WIDTH  ALU result
- in_carryout  input  1  ALU carryout
- in_overflow  input  1  ALU overflow
- out_valid  output  1  head entry present; high when count > 0
- out_ready  input  1  consumer accepts the head entry this cycle
- out_result  output  WIDTH  head entry result; 0 when empty
- out_carryout  output  1  head entry carryout; 0 when empty
- out_overflow  output  1  head entry overflow; 0 when empty
- out_zero  output  1  head entry zero flag; 0 when empty
- count  output  log2(DEPTH)+1  occupied entries, 0..DEPTH
- ovf_clear  input  1  synchronous clear of sticky_ovf and ovf_count
- sticky_ovf  output  1  set by any accepted entry with overflow
- ovf_count  output  8  saturating count of accepted entries with overflow

## Operation
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- On push: write {in_result, in_carryout, in_overflow, zero} at wr_ptr, where zero = (in_result == 0). Advance wr_ptr.
- On pop: advance rd_ptr. The out_* signals are a combinational read of the entry at rd_ptr, gated to 0 when count == 0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is +1 on push only, −1 on pop only, and unchanged on simultaneous push and pop.
- Full (count == DEPTH): in_ready = 0. A push is not accepted even if a pop happens the same cycle. There is no pass-through.
- Empty (count == 0): out_valid = 0. out_ready is ignored, and there is no bypass from input to output.
- in_valid while in_ready = 0: nothing is written. The producer must hold its data.
- The stored payload of an entry never changes between its push and its pop.
- sticky_ovf:
  - Set on a push with in_overflow = 1.
  - Cleared by ovf_clear.
  - If clear and set occur in the same cycle, set wins and sticky_ovf = 1.
- ovf_count:
  - +1 on a push with in_overflow = 1; saturates at 255.
  - Cleared to 0 by ovf_clear.
  - If clear and an overflow push occur in the same cycle, the result is 1.
- Status updates only on accepted pushes, not on pops.

## Timing
- Reset (reset_n low, asynchronous, takes effect immediately):
  - Pointers = 0, count = 0, out_valid = 0, in_ready = 1.
  - All out_* = 0, sticky_ovf = 0, ovf_count = 0.
  - Storage contents are don't-care and unobservable.
- Reset asserted mid-operation discards all queued entries. The first push after reset_n rises is the first entry seen at the output.
- Latency:
  - A push at edge N makes out_valid high and the data visible after edge N.
  - Minimum input-to-output latency is 1 cycle.
  - Steady-state throughput is 1 entry per cycle with continuous push and pop.
- in_ready and out_valid are derived from registered count only. There is no combinational path from in_valid to in_ready or from out_ready to out_valid.
- sticky_ovf and ovf_count update at the same edge as the accepting push.

## Test plan
- **Reset and empty:** hold reset_n = 0, then release. Require count = 0, in_ready = 1, out_valid = 0, out_result = 0. Assert out_ready = 1 for 3 cycles: count stays 0.
- **Ordering and flags:**
  - Push 0x00000005/co0/ov0, 0x00000000/co1/ov0, 0x80000000/co0/ov1 on consecutive cycles with out_ready = 0. Require count = 3.
  - Then pop all three. Require heads in that order, with out_zero = 0, 1, 0 and out_overflow = 0, 0, 1.
- **Full boundary:**
  - Push 4 entries (DEPTH = 4). Require in_ready = 0 and count = 4.
  - Assert in_valid with 0xDEADBEEF and out_ready = 1 in the same cycle. Require count = 3 and 0xDEADBEEF not stored.
  - Next cycle, the push is accepted and count = 4.
- **Wrap-around streaming:** continuous push/pop of 0..9 with out_ready = 1. Require out_result to match 0..9 in order, with count staying at or below 1 and the pointers wrapping twice.
- **Overflow status:**
  - Push 300 entries with in_overflow = 1. Require ovf_count = 255 and sticky_ovf = 1.
  - Assert ovf_clear together with an overflow push. Require ovf_count = 1 and sticky_ovf = 1.
  - Assert ovf_clear alone. Require both = 0.
- **Reset mid-operation:** with 3 entries queued, pulse reset_n low between clock edges. Require out_valid = 0 and count = 0 immediately. After release, push 0x0000000A; the next cycle head = 0x0000000A.
